// File: rtl/if_fetch_stage_if.sv
// Bundle of ROM, hazard/redirect and IF/ID signals of the instruction-fetch stage.
// The master modport is the fetch stage's view. The slave modport is the view of the ROM and the downstream pipeline.
interface if_fetch_stage_if;
   logic [31:0] rom_addr;
   logic [31:0] rom_data;
   logic        stall;
   logic        flush;
   logic        br_taken;
   logic [31:0] br_target;
   logic        jmp_en;
   logic [31:0] jmp_target;
   logic        jr_en;
   logic [31:0] jr_target;
   logic        exc_req;
   logic [31:0] pc;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc4;
   logic        if_id_valid;
   logic        fetch_fault;

   modport master (
      output rom_addr,
      input  rom_data,
      input  stall, flush,
      input  br_taken, br_target,
      input  jmp_en, jmp_target,
      input  jr_en, jr_target,
      input  exc_req,
      output pc, if_id_instr, if_id_pc4, if_id_valid, fetch_fault
   );

   modport slave (
      input  rom_addr,
      output rom_data,
      output stall, flush,
      output br_taken, br_target,
      output jmp_en, jmp_target,
      output jr_en, jr_target,
      output exc_req,
      input  pc, if_id_instr, if_id_pc4, if_id_valid, fetch_fault
   );
endinterface

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: PC register, next-PC selection and IF/ID pipeline register.
// Optional IF_BOUNDS_CHECK_EN squashes fetches beyond ROM_WORDS and raises fetch_fault.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] EXC_VECTOR = 32'h8000_0004,
   parameter int unsigned ROM_WORDS  = 32
) (
   input logic            clk,
   input logic            reset,
   if_fetch_stage_if.master bus
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;
   logic        fault_q, fault_d;
   logic [31:0] pc_plus4_s;
   logic        redirect_s;
   logic        squash_s;
   logic        oob_s;

   assign pc_plus4_s = pc_q + 32'd4;
   assign redirect_s = bus.exc_req | bus.jr_en | bus.br_taken | bus.jmp_en;
   assign squash_s   = redirect_s | bus.flush;

`ifdef IF_BOUNDS_CHECK_EN
   logic [29:0] word_idx_s;

   // In kernel space pc[31] is only the segment bit, so it does not count toward the word index.
   assign word_idx_s = {(EXC_VECTOR[31] ? 1'b0 : pc_q[31]), pc_q[30:2]};
   assign oob_s      = ({2'b00, word_idx_s} >= ROM_WORDS);
`else
   logic rom_words_unused_s;

   assign rom_words_unused_s = ^ROM_WORDS;
   assign oob_s              = 1'b0;
`endif

   // Next-PC selection: redirects in priority order, then stall, then sequential fetch.
   always_comb begin
      pc_d = pc_plus4_s;
      if (bus.exc_req) begin
         pc_d = EXC_VECTOR;
      end else if (bus.jr_en) begin
         pc_d = bus.jr_target;
      end else if (bus.br_taken) begin
         pc_d = bus.br_target;
      end else if (bus.jmp_en) begin
         pc_d = bus.jmp_target;
      end else if (bus.stall) begin
         pc_d = pc_q;
      end else begin
         pc_d = pc_plus4_s;
      end
   end

   // IF/ID next state: squash on flush/redirect, hold on stall, bubble on an out-of-range fetch.
   always_comb begin
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      fault_d = fault_q;
      if (squash_s) begin
         instr_d = 32'h0000_0000;
         pc4_d   = 32'h0000_0000;
         valid_d = 1'b0;
         fault_d = 1'b0;
      end else if (bus.stall) begin
         instr_d = instr_q;
         pc4_d   = pc4_q;
         valid_d = valid_q;
         fault_d = fault_q;
      end else if (oob_s) begin
         instr_d = 32'h0000_0000;
         pc4_d   = 32'h0000_0000;
         valid_d = 1'b0;
         fault_d = 1'b1;
      end else begin
         instr_d = bus.rom_data;
         pc4_d   = pc_plus4_s;
         valid_d = 1'b1;
         fault_d = 1'b0;
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q    <= RESET_PC;
         instr_q <= 32'h0000_0000;
         pc4_q   <= 32'h0000_0000;
         valid_q <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
         fault_q <= fault_d;
      end
   end

   assign bus.rom_addr    = pc_q;
   assign bus.pc          = pc_q;
   assign bus.if_id_instr = instr_q;
   assign bus.if_id_pc4   = pc4_q;
   assign bus.if_id_valid = valid_q;
   assign bus.fetch_fault = fault_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: directed vectors push hand-computed expectations, a monitor checks them.
module tb_if_fetch_stage;

   typedef struct {
      string       name;
      logic        stall, flush, br, jmp, jr, exc;
      logic [31:0] br_t, jmp_t, jr_t;
      logic [31:0] e_pc, e_instr, e_pc4;
      logic        e_valid, e_fault;
   } vec_t;

   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;
   vec_t exp_q[$];

   if_fetch_stage_if bus ();

   if_fetch_stage dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ROM: word0 from the test plan, words 1..31 = 0x2400_0000 + index, beyond that 0xDEAD_xxxx.
   function automatic logic [31:0] rom_word(input logic [31:0] a);
      if (a == 32'h0000_0000) return 32'h2004_3039;
      if (a[31:2] < 30'd32)  return 32'h2400_0000 + {2'b00, a[31:2]};
      return {16'hDEAD, a[15:0]};
   endfunction

   always_comb bus.rom_data = rom_word(bus.rom_addr);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input string nm,
                               input logic st, input logic fl,
                               input logic bt, input logic [31:0] btg,
                               input logic je, input logic [31:0] jt,
                               input logic jre, input logic [31:0] jrt,
                               input logic ex,
                               input logic [31:0] epc, input logic [31:0] ein,
                               input logic [31:0] ep4, input logic ev, input logic ef);
      vec_t v;
      v.name = nm; v.stall = st; v.flush = fl; v.br = bt; v.br_t = btg;
      v.jmp = je; v.jmp_t = jt; v.jr = jre; v.jr_t = jrt; v.exc = ex;
      v.e_pc = epc; v.e_instr = ein; v.e_pc4 = ep4; v.e_valid = ev; v.e_fault = ef;
      return v;
   endfunction

   task automatic drive_idle();
      bus.stall = 1'b0; bus.flush = 1'b0; bus.br_taken = 1'b0; bus.br_target = 32'h0;
      bus.jmp_en = 1'b0; bus.jmp_target = 32'h0; bus.jr_en = 1'b0; bus.jr_target = 32'h0;
      bus.exc_req = 1'b0;
   endtask

   // Apply one vector between edges, queue its expectation, and move to the next inter-edge slot.
   task automatic step(input vec_t v);
      bus.stall = v.stall; bus.flush = v.flush;
      bus.br_taken = v.br; bus.br_target = v.br_t;
      bus.jmp_en = v.jmp; bus.jmp_target = v.jmp_t;
      bus.jr_en = v.jr; bus.jr_target = v.jr_t;
      bus.exc_req = v.exc;
      exp_q.push_back(v);
      @(posedge clk);
      #2;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_pc"},    bus.pc,          32'h0);
      chk({tag, "_addr"},  bus.rom_addr,    32'h0);
      chk({tag, "_instr"}, bus.if_id_instr, 32'h0);
      chk({tag, "_pc4"},   bus.if_id_pc4,   32'h0);
      chk({tag, "_valid"}, {31'h0, bus.if_id_valid}, 32'h0);
      chk({tag, "_fault"}, {31'h0, bus.fetch_fault}, 32'h0);
   endtask

   // Monitor: one edge after a vector is queued, compare the registered outputs against it.
   always @(posedge clk) begin
      vec_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk({e.name, "_pc"},    bus.pc,          e.e_pc);
         chk({e.name, "_addr"},  bus.rom_addr,    e.e_pc);
         chk({e.name, "_instr"}, bus.if_id_instr, e.e_instr);
         chk({e.name, "_pc4"},   bus.if_id_pc4,   e.e_pc4);
         chk({e.name, "_valid"}, {31'h0, bus.if_id_valid}, {31'h0, e.e_valid});
         chk({e.name, "_fault"}, {31'h0, bus.fetch_fault}, {31'h0, e.e_fault});
      end
   end

   initial begin
      n_tests = 0;
      n_fail  = 0;
      reset   = 1'b0;
      drive_idle();
      #12;
      chk_reset_state("reset");
      #5;
      reset = 1'b1;

      //         name    st    fl    br    br_t          jmp   jmp_t         jr    jr_t          exc   pc            instr         pc4           v     f
      step(mk("first",   1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h4,        32'h2004_3039, 32'h4,       1'b1, 1'b0));
      step(mk("seq1",    1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h8,        32'h2400_0001, 32'h8,       1'b1, 1'b0));
      step(mk("stall1",  1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h8,        32'h2400_0001, 32'h8,       1'b1, 1'b0));
      step(mk("stall2",  1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h8,        32'h2400_0001, 32'h8,       1'b1, 1'b0));
      step(mk("unstall", 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'hC,        32'h2400_0002, 32'hC,       1'b1, 1'b0));
      step(mk("seq2",    1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h10,       32'h2400_0003, 32'h10,      1'b1, 1'b0));
      step(mk("branch",  1'b0, 1'b0, 1'b1, 32'h18,       1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h18,       32'h0,         32'h0,       1'b0, 1'b0));
      step(mk("br_tgt",  1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h1C,       32'h2400_0006, 32'h1C,      1'b1, 1'b0));
      step(mk("stl_jmp", 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h2C,       1'b0, 32'h0,        1'b0, 32'h2C,       32'h0,         32'h0,       1'b0, 1'b0));
      step(mk("stl_exc", 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h2C,       1'b0, 32'h0,        1'b1, 32'h8000_0004, 32'h0,        32'h0,       1'b0, 1'b0));
      step(mk("exc_tgt", 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h8000_0008, 32'hDEAD_0004, 32'h8000_0008, 1'b1, 1'b0));
      step(mk("flush",   1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h8000_000C, 32'h0,        32'h0,       1'b0, 1'b0));
      step(mk("stl_fl",  1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h8000_000C, 32'h0,        32'h0,       1'b0, 1'b0));
      step(mk("seq3",    1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h8000_0010, 32'hDEAD_000C, 32'h8000_0010, 1'b1, 1'b0));
      step(mk("jr_pri",  1'b0, 1'b0, 1'b1, 32'h40,       1'b1, 32'h44,       1'b1, 32'h20,       1'b0, 32'h20,       32'h0,         32'h0,       1'b0, 1'b0));
      step(mk("br_pri",  1'b0, 1'b0, 1'b1, 32'h40,       1'b1, 32'h44,       1'b0, 32'h0,        1'b0, 32'h40,       32'h0,         32'h0,       1'b0, 1'b0));
      step(mk("seq4",    1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h44,       32'h2400_0010, 32'h44,      1'b1, 1'b0));
      step(mk("jmp_top", 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,       1'b0, 32'hFFFF_FFFC, 32'h0,        32'h0,       1'b0, 1'b0));
`ifdef IF_BOUNDS_CHECK_EN
      step(mk("wrap",    1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'h0,         32'h0,       1'b0, 1'b1));
      step(mk("wrap_st", 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'h0,         32'h0,       1'b0, 1'b1));
`else
      step(mk("wrap",    1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'hDEAD_FFFC, 32'h0,       1'b1, 1'b0));
      step(mk("wrap_st", 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'hDEAD_FFFC, 32'h0,       1'b1, 1'b0));
`endif
      step(mk("restart", 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h4,        32'h2004_3039, 32'h4,       1'b1, 1'b0));
      step(mk("jr_80",   1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h80,       1'b0, 32'h80,       32'h0,         32'h0,       1'b0, 1'b0));
`ifdef IF_BOUNDS_CHECK_EN
      step(mk("oob",     1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h84,       32'h0,         32'h0,       1'b0, 1'b1));
`else
      step(mk("oob",     1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h84,       32'hDEAD_0080, 32'h84,      1'b1, 1'b0));
`endif
      step(mk("jmp_20",  1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h20,       1'b0, 32'h0,        1'b0, 32'h20,       32'h0,         32'h0,       1'b0, 1'b0));

      // Mid-run reset between edges must clear state without a clock edge.
      drive_idle();
      reset = 1'b0;
      #1;
      chk_reset_state("async_rst");
      #2;
      reset = 1'b1;
      step(mk("post_rst", 1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h4,        32'h2004_3039, 32'h4,       1'b1, 1'b0));

      @(posedge clk);
      #3;
      chk("queue_drained", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
